// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - shared types and constants for the image sequencer
package image_pkg;

  typedef enum logic [1:0] {
    SHOW     = 2'd0,
    FADE_OUT = 2'd1,
    SWITCH   = 2'd2,
    FADE_IN  = 2'd3
  } seq_state_t;

  localparam logic [4:0] LEVEL_MAX = 5'd16;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Scale one 4-bit channel by a 0..16 level; 16 gives the channel back unchanged.
  function automatic logic [3:0] scale4(input logic [3:0] c, input logic [4:0] lvl);
    logic [8:0] p;
    p = {5'd0, c} * {4'd0, lvl};
    return 4'(p >> 4);
  endfunction

endpackage

// File: rtl/pixel_dimmer.sv
// rtl/pixel_dimmer.sv - combinational 12-bit rgb brightness scaler
module pixel_dimmer
  import image_pkg::*;
(
  input  logic [11:0] rgb_i,
  input  logic [4:0]  level_i,
  output logic [11:0] rgb_o
);

  rgb12_t px_in;
  rgb12_t px_out;

  assign px_in = rgb12_t'(rgb_i);

  // Each channel is scaled independently by the same level.
  always_comb begin
    px_out   = '0;
    px_out.r = scale4(px_in.r, level_i);
    px_out.g = scale4(px_in.g, level_i);
    px_out.b = scale4(px_in.b, level_i);
  end

  assign rgb_o = px_out;

endmodule

// File: rtl/image_sequencer.sv
// rtl/image_sequencer.sv - frame-level image dwell/fade/switch scheduler with dimmed rgb mux
module image_sequencer
  import image_pkg::*;
#(
  parameter int NUM_IMAGES           = 2,
  parameter int DWELL_FRAMES         = 600,
  parameter int FADE_FRAMES_PER_STEP = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic                          skip_req,
  output logic                          skip_ack,
  input  logic                          pause,
  input  logic [NUM_IMAGES*12-1:0]      img_rgb,
  output logic [$clog2(NUM_IMAGES)-1:0] sel,
  output logic [31:0]                   frame,
  output logic [4:0]                    level,
  output logic [3:0]                    r,
  output logic [3:0]                    g,
  output logic [3:0]                    b
);

  localparam int SEL_W = $clog2(NUM_IMAGES);
  localparam int DW    = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam int STW   = (FADE_FRAMES_PER_STEP > 1) ? $clog2(FADE_FRAMES_PER_STEP) : 1;

  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_IMAGES - 1);
  localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL_FRAMES - 1);
  localparam logic [STW-1:0]   STEP_LAST  = STW'(FADE_FRAMES_PER_STEP - 1);

  seq_state_t       state_q;
  logic [SEL_W-1:0] sel_q;
  logic [31:0]      frame_q;
  logic [4:0]       level_q;
  logic [DW-1:0]    dwell_q;
  logic [STW-1:0]   step_q;
  logic             skip_ack_q;

  logic             step_evt;
  logic [STW-1:0]   step_next;
  logic [11:0]      src_rgb;
  logic [11:0]      rgb_d;
  logic [11:0]      rgb_q;

  // A fade step lands on the last frame of each step window.
  assign step_evt  = (step_q == STEP_LAST);
  assign step_next = step_evt ? '0 : step_q + 1'b1;

  // Sequencer FSM and counters; everything advances only on frame_start so changes fall in blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FADE_IN;
      sel_q      <= '0;
      frame_q    <= '0;
      level_q    <= '0;
      dwell_q    <= '0;
      step_q     <= '0;
      skip_ack_q <= 1'b0;
    end else begin
      skip_ack_q <= 1'b0;
      if (frame_start) begin
        frame_q <= frame_q + 32'd1;
        unique case (state_q)
          FADE_IN: begin
            step_q <= step_next;
            if (step_evt) begin
              level_q <= level_q + 5'd1;
              if (level_q == LEVEL_MAX - 5'd1) begin
                state_q <= SHOW;
                dwell_q <= '0;
              end
            end
          end
          SHOW: begin
            if (!pause) dwell_q <= dwell_q + 1'b1;
            if (skip_req) skip_ack_q <= 1'b1;
            if (skip_req || (!pause && dwell_q == DWELL_LAST)) begin
              state_q <= FADE_OUT;
              step_q  <= '0;
            end
          end
          FADE_OUT: begin
            step_q <= step_next;
            if (step_evt) begin
              level_q <= level_q - 5'd1;
              if (level_q == 5'd1) state_q <= SWITCH;
            end
          end
          SWITCH: begin
            sel_q   <= (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
            frame_q <= '0;
            state_q <= FADE_IN;
            step_q  <= '0;
          end
          default: state_q <= FADE_IN;
        endcase
      end
    end
  end

  assign src_rgb = img_rgb[sel_q*12 +: 12];

  pixel_dimmer u_dimmer (
    .rgb_i   (src_rgb),
    .level_i (level_q),
    .rgb_o   (rgb_d)
  );

  // Register the dimmed pixel so the VGA stage sees a clean one-cycle pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_q <= '0;
    else        rgb_q <= rgb_d;
  end

  assign skip_ack = skip_ack_q;
  assign sel      = sel_q;
  assign frame    = frame_q;
  assign level    = level_q;
  assign r        = rgb_q[11:8];
  assign g        = rgb_q[7:4];
  assign b        = rgb_q[3:0];

endmodule
